// File: rtl/prng_seq_ctrl_pkg.sv
// Shared types and defaults for the PRNG sequencer.
// Holds the FSM encoding and width defaults used by prng_seq_ctrl.
package prng_seq_ctrl_pkg;

  localparam int AW_DEF = 15;
  localparam int DW_DEF = 32;

  // FETCH counts 0,1,2 so prng_out lands 3 cycles after read_clk is sampled
  localparam logic [1:0] FETCH_LAST = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GEN   = 3'd2,
    DONE  = 3'd3,
    FETCH = 3'd4
  } state_t;

endpackage

// File: rtl/prng_seq_ctrl_edge.sv
// Rising-edge detector against a 1-cycle registered copy.
// Reset and run both reload the copy, so a level held through reset is no edge.
module prng_seq_ctrl_edge (
  input  logic clk,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/prng_seq_ctrl.sv
// PRNG fill/readback sequencer between the HPS, a PRNG core and a buffer RAM.
// Optional XOR checksum of written words: define PRNG_SEQ_CTRL_CHECKSUM_EN.
module prng_seq_ctrl
  import prng_seq_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          fsm_reset,
  input  logic          prng_start,
  input  logic [DW-1:0] seed,
  input  logic          read_clk,
  input  logic [AW-1:0] r_addr,
  input  logic          rec_done,
  output logic          gen_done,
  output logic [DW-1:0] prng_out,
  output logic          core_load,
  output logic [DW-1:0] core_seed,
  output logic          core_step,
  input  logic          core_valid,
  input  logic [DW-1:0] core_value,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] checksum
);

  localparam logic [AW-1:0] LAST = '1;

  logic          rst;
  logic          start_rise;
  logic          read_rise;
  logic          done_rise;
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] dout_q;
  logic [1:0]    fcnt;

  assign rst = reset_reset | fsm_reset;

  prng_seq_ctrl_edge u_start_edge (
    .clk  (clk_clk),
    .d    (prng_start),
    .rise (start_rise)
  );

  prng_seq_ctrl_edge u_read_edge (
    .clk  (clk_clk),
    .d    (read_clk),
    .rise (read_rise)
  );

  prng_seq_ctrl_edge u_done_edge (
    .clk  (clk_clk),
    .d    (rec_done),
    .rise (done_rise)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_rise) state_nx = LOAD;
      LOAD:    state_nx = GEN;
      GEN:     if (core_valid && wr_ptr == LAST) state_nx = DONE;
      DONE: begin
        if (start_rise)     state_nx = LOAD;
        else if (done_rise) state_nx = IDLE;
        else if (read_rise) state_nx = FETCH;
      end
      FETCH:   if (fcnt == FETCH_LAST) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      raddr_q <= '0;
      seed_q  <= '0;
      dout_q  <= '0;
      fcnt    <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == LOAD) seed_q <= seed;
      // last write parks the pointer; LOAD rewinds it
      if (state == LOAD)
        wr_ptr <= '0;
      else if (mem_we && wr_ptr != LAST)
        wr_ptr <= wr_ptr + 1'b1;
      if (state == DONE && state_nx == FETCH) raddr_q <= r_addr;
      if (state == FETCH) fcnt <= fcnt + 2'd1;
      else                fcnt <= '0;
      if (state == FETCH && fcnt == FETCH_LAST) dout_q <= mem_rdata;
    end
  end

  assign core_load = (state == LOAD);
  assign core_step = (state == GEN);
  assign core_seed = seed_q;
  assign mem_we    = core_step & core_valid;
  assign mem_waddr = wr_ptr;
  assign mem_wdata = core_value;
  assign mem_raddr = raddr_q;
  assign gen_done  = (state == DONE) || (state == FETCH);
  assign prng_out  = dout_q;

`ifdef PRNG_SEQ_CTRL_CHECKSUM_EN
  logic [DW-1:0] cks_q;

  always_ff @(posedge clk_clk) begin
    if (rst)                cks_q <= '0;
    else if (state == LOAD) cks_q <= '0;
    else if (mem_we)        cks_q <= cks_q ^ core_value;
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Scoreboard bench for prng_seq_ctrl with AW=4: fill, readback, priority, reset.
// Behavioural PRNG core and 1-cycle-latency RAM are modelled here.
module tb_prng_seq_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_reset;
  logic          fsm_reset;
  logic          prng_start;
  logic [DW-1:0] seed;
  logic          read_clk;
  logic [AW-1:0] r_addr;
  logic          rec_done;
  logic          gen_done;
  logic [DW-1:0] prng_out;
  logic          core_load;
  logic [DW-1:0] core_seed;
  logic          core_step;
  logic          core_valid;
  logic [DW-1:0] core_value;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] checksum;

  logic [DW-1:0] ram [N];
  logic [DW-1:0] word_src [N];
  wr_t           exp_wr [$];
  logic [DW-1:0] exp_rd [$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            src_idx = 0;
  int            load_cnt = 0;
  int            nwr = 0;
  int            last_we = -1;
  int            gd_rise = -1;
  bit            gd_q = 1'b0;
  bit            toggle = 1'b0;
  logic [DW-1:0] load_seed = '0;
  logic [DW-1:0] exp_cks;

  prng_seq_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .fsm_reset   (fsm_reset),
    .prng_start  (prng_start),
    .seed        (seed),
    .read_clk    (read_clk),
    .r_addr      (r_addr),
    .rec_done    (rec_done),
    .gen_done    (gen_done),
    .prng_out    (prng_out),
    .core_load   (core_load),
    .core_seed   (core_seed),
    .core_step   (core_step),
    .core_valid  (core_valid),
    .core_value  (core_value),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // core model + write scoreboard
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (core_load) begin
      load_cnt++;
      load_seed = core_seed;
      src_idx = 0;
    end
    core_valid = toggle ? ~core_valid : 1'b1;
    core_value = word_src[src_idx % N];
    #1;
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        check("wr_extra", 64'd1, 64'd0);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 64'(mem_waddr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
      src_idx++;
      nwr++;
      last_we = cyc;
    end
    if (gen_done && !gd_q) gd_rise = cyc;
    gd_q = gen_done;
  end

  task automatic run_gen(input logic [DW-1:0] s, input bit tog,
                         input bit cks_pat);
    logic [DW-1:0] w;
    int i;
    @(negedge clk);
    exp_cks = '0;
    for (int k = 0; k < N; k++) begin
      if (cks_pat) w = (k < 4) ? (32'h1 << k) : 32'h0;
      else         w = s ^ (32'(k) * 32'h9E3779B9);
      word_src[k] = w;
      exp_wr.push_back('{addr: AW'(k), data: w});
`ifdef PRNG_SEQ_CTRL_CHECKSUM_EN
      exp_cks ^= w;
`endif
    end
    toggle = tog;
    load_cnt = 0;
    nwr = 0;
    gd_rise = -1;
    last_we = -1;
    seed = s;
    prng_start = 1'b1;
    repeat (2) @(negedge clk);
    i = 0;
    while (!gen_done && i < 200) begin
      @(negedge clk);
      i++;
    end
    #3;
    if (i >= 200) check("gen_timeout", 64'd0, 64'd1);
    check("load_pulses", 64'(load_cnt), 64'd1);
    check("load_seed", 64'(load_seed), 64'(s));
    check("wr_count", 64'(nwr), 64'(N));
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("done_lat", 64'(gd_rise), 64'(last_we + 1));
    check("step_off", 64'(core_step), 64'd0);
    check("checksum", 64'(checksum), 64'(exp_cks));
    prng_start = 1'b0;
    toggle = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit poke);
    logic [DW-1:0] old;
    logic [DW-1:0] exp;
    @(negedge clk);
    old = prng_out;
    r_addr = a;
    read_clk = 1'b1;
    exp_rd.push_back(word_src[a]);
    @(negedge clk);
    read_clk = 1'b0;
    @(negedge clk);
    if (poke) begin
      read_clk = 1'b1;
      r_addr = ~a;
    end
    @(negedge clk);
    check("rd_early", 64'(prng_out), 64'(old));
    @(negedge clk);
    exp = exp_rd.pop_front();
    check("rd_data", 64'(prng_out), 64'(exp));
    read_clk = 1'b0;
    repeat (5) @(negedge clk);
    check("rd_hold", 64'(prng_out), 64'(exp));
    check("rd_done", 64'(gen_done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old;
    int i;
    reset_reset = 1'b1;
    fsm_reset   = 1'b0;
    prng_start  = 1'b0;
    seed        = '0;
    read_clk    = 1'b0;
    r_addr      = '0;
    rec_done    = 1'b0;
    core_valid  = 1'b1;
    core_value  = '0;
    for (int k = 0; k < N; k++) word_src[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_gen_done", 64'(gen_done), 64'd0);
    check("rst_prng_out", 64'(prng_out), 64'd0);
    check("rst_core_load", 64'(core_load), 64'd0);
    check("rst_core_step", 64'(core_step), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_core_seed", 64'(core_seed), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    reset_reset = 1'b0;

    run_gen(32'hDEADBEEF, 1'b0, 1'b0);
    do_read(4'd7, 1'b1);
    do_read(4'd0, 1'b0);
    do_read(4'd15, 1'b0);

    // restart straight from DONE with a stuttering core
    run_gen(32'h12345678, 1'b1, 1'b0);
    do_read(4'd3, 1'b0);

    @(negedge clk);
    old = prng_out;
    read_clk = 1'b1;
    rec_done = 1'b1;
    @(negedge clk);
    check("both_idle", 64'(gen_done), 64'd0);
    repeat (4) @(negedge clk);
    check("both_out", 64'(prng_out), 64'(old));
    check("both_stay", 64'(gen_done), 64'd0);
    read_clk = 1'b0;
    rec_done = 1'b0;

    run_gen(32'h0000_0001, 1'b0, 1'b1);
`ifdef PRNG_SEQ_CTRL_CHECKSUM_EN
    check("cks_0f", 64'(checksum), 64'hF);
`else
    check("cks_zero", 64'(checksum), 64'h0);
`endif

    @(negedge clk);
    rec_done = 1'b1;
    @(negedge clk);
    rec_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      word_src[k] = 32'hC0DE0000 + 32'(k);
      exp_wr.push_back('{addr: AW'(k), data: word_src[k]});
    end
    seed = 32'hCAFEF00D;
    prng_start = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      #2;
      i++;
    end while (!(mem_we && mem_waddr == 4'd5) && i < 100);
    if (i >= 100) check("abort_timeout", 64'd0, 64'd1);
    fsm_reset = 1'b1;
    @(negedge clk);
    #2;
    exp_wr.delete();
    check("abort_gen_done", 64'(gen_done), 64'd0);
    check("abort_step", 64'(core_step), 64'd0);
    check("abort_load", 64'(core_load), 64'd0);
    check("abort_we", 64'(mem_we), 64'd0);
    check("abort_out", 64'(prng_out), 64'd0);
    check("abort_seed", 64'(core_seed), 64'd0);
    check("abort_cks", 64'(checksum), 64'd0);
    load_cnt = 0;
    fsm_reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check("held_start", 64'(load_cnt), 64'd0);
    check("held_step", 64'(core_step), 64'd0);
    prng_start = 1'b0;

    run_gen(32'hA5A5_0F0F, 1'b0, 1'b0);
    do_read(4'd5, 1'b0);
    do_read(4'd14, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prng_seq_ctrl.md
PRNG_SEQ_CTRL -- requirements
Module: prng_seq_ctrl

Interface
REQ-001 SHALL have parameter AW, default 15: buffer address width; the buffer holds 2**AW words.
REQ-002 SHALL have parameter DW, default 32: seed and sample width.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fsm_reset, input, 1 bit: HPS soft reset (level).
REQ-006 SHALL have port prng_start, input, 1 bit: HPS start request (rising edge).
REQ-007 SHALL have port seed, input, DW bits: PRNG seed, latched at start.
REQ-008 SHALL have port read_clk, input, 1 bit: HPS read strobe (rising edge).
REQ-009 SHALL have port r_addr, input, AW bits: HPS read address.
REQ-010 SHALL have port rec_done, input, 1 bit: HPS readback complete (rising edge).
REQ-011 SHALL have port gen_done, output, 1 bit: buffer full and readable.
REQ-012 SHALL have port prng_out, output, DW bits: read data to the HPS.
REQ-013 SHALL have outputs core_load (1), core_seed (DW) and core_step (1), plus inputs core_valid (1) and core_value (DW), as the PRNG core interface.
REQ-014 SHALL have outputs mem_we (1), mem_waddr (AW), mem_wdata (DW) and mem_raddr (AW), plus input mem_rdata (DW): a buffer RAM with 1-cycle read latency.
REQ-015 SHALL have port checksum, output, DW bits: running checksum (see Configuration).

Function
REQ-016 SHALL treat all HPS inputs as synchronous to clk_clk and detect rising edges against a 1-cycle registered copy.
REQ-017 SHALL implement states IDLE, LOAD, GEN, DONE and FETCH.
REQ-018 SHALL, in IDLE on a prng_start edge: latch seed into core_seed, pulse core_load for 1 cycle, go to LOAD.
REQ-019 SHALL, in LOAD: clear wr_ptr to 0, go to GEN after 1 cycle.
REQ-020 SHALL, in GEN: hold core_step high and, on each cycle with core_valid high, assert mem_we with mem_waddr=wr_ptr and mem_wdata=core_value, then increment wr_ptr.
REQ-021 SHALL, on the write at wr_ptr = 2**AW-1: deassert core_step the next cycle, go to DONE, with no wr_ptr wrap write.
REQ-022 SHALL ignore prng_start, read_clk and rec_done edges in LOAD and GEN.
REQ-023 SHALL hold gen_done high in DONE and FETCH only, and low in all other states.
REQ-024 SHALL, in DONE on a read_clk edge: drive mem_raddr=r_addr, go to FETCH.
REQ-025 SHALL, in FETCH: load prng_out from mem_rdata, return to DONE.
REQ-026 SHALL update prng_out exactly 3 cycles after the first cycle read_clk is sampled high; prng_out holds otherwise.
REQ-027 SHALL ignore read_clk edges in FETCH.
REQ-028 SHALL, in DONE on a rec_done edge, go to IDLE.
REQ-029 SHALL give rec_done priority over read_clk when both edges occur in the same cycle.
REQ-030 SHALL, in DONE on a prng_start edge, regenerate via the IDLE start action (REQ-018).
REQ-031 SHALL give prng_start priority over rec_done when both edges occur in the same cycle.

Reset
REQ-032 SHALL, on reset_reset or fsm_reset high, within 1 cycle enter IDLE with wr_ptr=0, prng_out=0, checksum=0, gen_done=0, core_load=0, core_step=0, mem_we=0, core_seed=0, and edge registers loaded with the current input values.
REQ-033 SHALL obey reset in any state, including mid-GEN; partially written buffer contents are don't-care.
REQ-034 SHALL not generate a prng_start edge from a prng_start that is held high through reset.

Configuration
REQ-035 SHALL, with PRNG_SEQ_CTRL_CHECKSUM_EN defined: clear checksum at LOAD and XOR each written core_value into it, valid in DONE.
REQ-036 SHALL, without PRNG_SEQ_CTRL_CHECKSUM_EN: drive checksum constant 0 and contain no accumulator logic.

Structure
REQ-037 SHALL take the state enum, AW/DW defaults and the state encoding from package prng_seq_ctrl_pkg.
REQ-038 SHALL implement rising-edge detection in one sub-module, prng_seq_ctrl_edge, instantiated once per edge-sensitive input (3 instances).

Verification
REQ-039 SHALL verify, with AW=4 and core_valid always high: seed=0xDEADBEEF plus a start edge -> core_load pulses once with core_seed=0xDEADBEEF; 16 writes to addresses 0..15; gen_done rises the cycle after the last write.
REQ-040 SHALL verify, with AW=4 and core_valid toggling 1/0: exactly 16 writes, address sequence gap-free, core_step low after the last write.
REQ-041 SHALL verify, in DONE: r_addr=7 plus a read_clk edge -> prng_out equals word 7 exactly 3 cycles later; a second edge during FETCH is ignored.
REQ-042 SHALL verify, in DONE: read_clk and rec_done edges in the same cycle -> IDLE, gen_done=0, prng_out unchanged.
REQ-043 SHALL verify: fsm_reset pulsed mid-GEN at wr_ptr=5 -> next cycle IDLE with all outputs at reset values; a new start regenerates all 16 words from address 0.
REQ-044 SHALL verify, with the macro defined: words 1,2,4,8 -> checksum=0xF; without the macro, checksum stays 0.
